// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion constants: round count, round constants,
// S-box table and the controller state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/key_round.sv
// One AES-128 key-expansion step: RotWord/SubWord/rcon on the last word,
// then the XOR chain across the four words of the previous round key.
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_prev,
  input  logic [7:0]   rcon,
  output logic [127:0] key_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] o0, o1, o2, o3;

  // combinational round: word 0 sits in the top 32 bits
  always_comb begin
    w0 = key_prev[127:96];
    w1 = key_prev[95:64];
    w2 = key_prev[63:32];
    w3 = key_prev[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    o0 = w0 ^ t;
    o1 = w1 ^ o0;
    o2 = w2 ^ o1;
    o3 = w3 ^ o2;
    key_next = {o0, o1, o2, o3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a loaded key one round per clock
// through a single key_round instance and serves registered round-key reads.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no key loaded since reset; reads ignored
// ST_EXPAND | iterating key_round, rk[rnd+1] written each clock
// ST_READY  | all 11 round keys valid; reads served with 1-cycle latency
module key_schedule_ctrl #(
  parameter int NR = 10  // only 10 (AES-128) is supported
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic         rk_err
);

  import aes_pkg::*;

  localparam logic [3:0] RND_LAST = 4'(NR - 1);
  localparam logic [3:0] IDX_MAX  = 4'(NR);

  ks_state_t    state;
  logic [3:0]   rnd;
  logic [3:0]   rnd_nxt;
  logic [127:0] cur;
  logic [127:0] nxt;
  logic [127:0] rk [0:10];

  assign rnd_nxt = rnd + 4'd1;

  key_round u_key_round (
    .key_prev (cur),
    .rcon     (RCON[rnd]),
    .key_next (nxt)
  );

  // FSM, round-key store and registered read port; key_load beats a read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rnd       <= 4'd0;
      cur       <= '0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_err    <= 1'b0;
      rk_out    <= '0;
    end else begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      if (key_load) begin
        rk[0]     <= key_in;
        cur       <= key_in;
        rnd       <= 4'd0;
        state     <= ST_EXPAND;
        busy      <= 1'b1;
        key_ready <= 1'b0;
      end else begin
        case (state)
          ST_EXPAND: begin
            rk[rnd_nxt] <= nxt;
            cur         <= nxt;
            rnd         <= rnd_nxt;
            if (rnd == RND_LAST) begin
              state     <= ST_READY;
              busy      <= 1'b0;
              key_ready <= 1'b1;
            end
          end
          ST_READY: begin
            if (rk_req) begin
              rk_valid <= 1'b1;
              if (rk_idx > IDX_MAX) begin
                rk_err <= 1'b1;
                rk_out <= '0;
              end else begin
                rk_out <= rk[rk_idx];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: expected read responses are queued
// at issue time and popped by an independent monitor on the falling edge.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic         rk_err;

  key_schedule_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .busy      (busy),
    .key_ready (key_ready),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_out    (rk_out),
    .rk_err    (rk_err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363_62636363_62636363_62636363;

  typedef struct {
    logic         err;
    logic [127:0] out;
    int           due;
  } resp_t;

  resp_t        exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] ref_rk [0:10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference model: FIPS-197 word-wise expansion, S-box derived from GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] av = 8'(a);
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gf_mul(av, 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // monitor: every rk_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (rk_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rk_valid actual=1 required=0 cycle=%0d", cyc);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("rk_latency", 128'(cyc), 128'(e.due));
          check("rk_err", 128'(rk_err), 128'(e.err));
          check("rk_out", rk_out, e.out);
        end
      end else begin
        check("rk_err_without_valid", 128'(rk_err), 128'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  // called 1ns after a load edge; ready must appear after exactly 10 edges
  task automatic wait_ready();
    int edges = 0;
    while (key_ready !== 1'b1 && edges < 20) begin
      check("busy_during_expand", 128'(busy), 128'd1);
      tick();
      edges++;
    end
    check("ready_latency", 128'(edges), 128'd10);
    check("busy_at_ready", 128'(busy), 128'd0);
  endtask

  task automatic issue(input logic [3:0] idx, input bit push,
                       input logic err, input logic [127:0] out);
    resp_t e;
    rk_req = 1'b1;
    rk_idx = idx;
    if (push) begin
      e.err = err;
      e.out = out;
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic req_model(input int idx);
    if (idx > 10) issue(4'(idx), 1'b1, 1'b1, '0);
    else          issue(4'(idx), 1'b1, 1'b0, ref_rk[idx]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    rst = 1'b1;
    key_load = 1'b0;
    key_in = '0;
    rk_req = 1'b0;
    rk_idx = 4'd0;
    build_sbox();
    repeat (3) tick();
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_key_ready", 128'(key_ready), 128'd0);
    check("reset_rk_valid", 128'(rk_valid), 128'd0);
    check("reset_rk_out", rk_out, 128'd0);
    rst = 1'b0;
    tick();

    // reads in IDLE are ignored
    issue(4'd0, 1'b0, 1'b0, '0);
    issue(4'd5, 1'b0, 1'b0, '0);
    rk_req = 1'b0;
    check("idle_key_ready", 128'(key_ready), 128'd0);

    // basic FIPS expansion, with a read pending throughout EXPAND
    model_expand(FIPS_KEY);
    check("model_fips_rk10", ref_rk[10], FIPS_RK10);
    load(FIPS_KEY);
    rk_req = 1'b1;
    rk_idx = 4'd3;
    wait_ready();
    rk_req = 1'b0;
    issue(4'd1, 1'b1, 1'b0, FIPS_RK1);
    issue(4'd10, 1'b1, 1'b0, FIPS_RK10);
    issue(4'd0, 1'b1, 1'b0, FIPS_KEY);
    req_model(11);
    req_model(15);
    for (int i = 0; i <= 10; i++) req_model(i);
    rk_req = 1'b0;
    repeat (2) tick();

    // restart with key 0 at cycle 5 of EXPAND
    load(FIPS_KEY);
    repeat (4) tick();
    model_expand('0);
    load('0);
    wait_ready();
    issue(4'd1, 1'b1, 1'b0, ZERO_RK1);
    req_model(7);
    rk_req = 1'b0;
    repeat (2) tick();

    // asynchronous reset mid-EXPAND
    load(FIPS_KEY);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("async_busy", 128'(busy), 128'd0);
    check("async_key_ready", 128'(key_ready), 128'd0);
    check("async_rk_valid", 128'(rk_valid), 128'd0);
    check("async_rk_err", 128'(rk_err), 128'd0);
    check("async_rk_out", rk_out, 128'd0);
    repeat (2) tick();
    rst = 1'b0;
    issue(4'd0, 1'b0, 1'b0, '0);
    issue(4'd1, 1'b0, 1'b0, '0);
    rk_req = 1'b0;
    check("post_reset_busy", 128'(busy), 128'd0);
    check("post_reset_key_ready", 128'(key_ready), 128'd0);
    model_expand(FIPS_KEY);
    load(FIPS_KEY);
    wait_ready();
    issue(4'd1, 1'b1, 1'b0, FIPS_RK1);
    issue(4'd10, 1'b1, 1'b0, FIPS_RK10);
    rk_req = 1'b0;
    repeat (2) tick();

    // key_load and rk_req together in READY: load wins
    k = {$urandom, $urandom, $urandom, $urandom};
    key_load = 1'b1;
    key_in   = k;
    rk_req   = 1'b1;
    rk_idx   = 4'd2;
    tick();
    key_load = 1'b0;
    rk_req   = 1'b0;
    check("collision_busy", 128'(busy), 128'd1);
    model_expand(k);
    wait_ready();
    req_model(2);
    rk_req = 1'b0;
    tick();

    // randomized keys and read traffic
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      load(k);
      wait_ready();
      for (int j = 0; j < 25; j++) begin
        if ($urandom_range(0, 3) != 0) begin
          req_model(int'($urandom_range(0, 15)));
        end else begin
          rk_req = 1'b0;
          tick();
        end
      end
      rk_req = 1'b0;
      repeat (2) tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter: NR, 10, number of AES-128 expansion rounds; only the value 10 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: key_load  input  1  single-cycle strobe that starts an expansion of key_in.
REQ-005 Port: key_in  input  128  cipher key, word 0 in bits [127:96]; sampled only on the key_load edge.
REQ-006 Port: busy  output  1  high while the state is EXPAND.
REQ-007 Port: key_ready  output  1  high while the state is READY (all 11 round keys valid).
REQ-008 Port: rk_req  input  1  round-key read request.
REQ-009 Port: rk_idx  input  4  round-key index, 0..10.
REQ-010 Port: rk_valid  output  1  single-cycle strobe: rk_out and rk_err are valid.
REQ-011 Port: rk_out  output  128  requested round key.
REQ-012 Port: rk_err  output  1  qualifies rk_valid: the request index was out of range.

Function
REQ-013 The block SHALL have exactly one round-expansion datapath and iterate it, one round per clock, over a registered current key.
REQ-014 The FSM SHALL have three states (IDLE, EXPAND, READY) and SHALL leave IDLE only on key_load.
- IDLE -> EXPAND on key_load.
- EXPAND -> READY when round counter = NR-1 completes.
- READY -> EXPAND on key_load.
REQ-015 On the key_load edge the block SHALL:
- write rk[0] := key_in and cur := key_in;
- clear the round counter rnd to 0;
- enter EXPAND.
REQ-016 On each EXPAND edge the block SHALL compute nxt = round(cur, rcon[rnd]), then write rk[rnd+1] := nxt, cur := nxt and rnd := rnd+1.
REQ-017 rcon[0..9] SHALL be 01,02,04,08,10,20,40,80,1b,36 in byte 0 (bits [31:24]) of the word.
REQ-018 key_ready SHALL rise exactly 10 clock edges after the key_load edge; busy SHALL be high for exactly those 10 cycles.
REQ-019 A key_load during EXPAND SHALL restart the expansion from the new key_in; the partial results SHALL be discarded (overwritten).
REQ-020 A rk_req in READY SHALL produce rk_valid=1 on the next cycle with rk_out = rk[rk_idx], registered, 1-cycle latency.
- Back-to-back requests SHALL be served every cycle.
REQ-021 If rk_idx > 10, the block SHALL drive rk_valid=1, rk_err=1 and rk_out=0.
REQ-022 A rk_req outside READY SHALL be ignored: no rk_valid.
REQ-023 If key_load and rk_req coincide in READY, key_load SHALL win and the request SHALL be dropped.
REQ-024 rk_valid and rk_err SHALL be high for one cycle per accepted request and low otherwise.
REQ-025 The round-key store SHALL be written only by load/EXPAND; reads never modify it.

Reset
REQ-026 Asserting rst, at any time including mid-EXPAND, SHALL asynchronously:
- force IDLE;
- clear rnd, cur and all rk[0..10] to 0;
- clear busy, key_ready, rk_valid and rk_err to 0;
- clear rk_out to 0.
REQ-027 After rst deasserts, the block SHALL stay in IDLE until the next key_load.

Structure
REQ-028 Shared package aes_pkg SHALL hold NR, the rcon table, the S-box table and the FSM state enum.
REQ-029 One combinational sub-module key_round SHALL compute one expansion step: (in 128, rcon 8) -> out 128.
- key_round applies RotWord, SubWord (4 S-box lookups) and the XOR chain.
REQ-030 The controller SHALL instantiate key_round exactly once.

Verification
REQ-031 Basic expansion: key_load with key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c.
- key_ready SHALL rise 10 edges later.
- rk_idx=1 -> a0fafe17_88542cb1_23a33939_2a6c7605.
- rk_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- rk_idx=0 -> key_in.
REQ-032 Restart: key_load with the FIPS key, then key_load with key_in=0 at cycle 5 of EXPAND.
- key_ready SHALL rise 10 edges after the second load.
- rk_idx=1 -> 62636363_62636363_62636363_62636363.
REQ-033 Read rules:
- rk_req in IDLE and in EXPAND -> no rk_valid.
- rk_idx=11 and rk_idx=15 in READY -> rk_valid=1, rk_err=1, rk_out=0.
- Streaming idx 0..10 on consecutive cycles -> 11 consecutive rk_valid pulses in order.
REQ-034 Reset mid-EXPAND: assert rst at cycle 4.
- All outputs SHALL be 0 immediately, without waiting for a clock edge.
- After release: no rk_valid on rk_req; a new FIPS load reproduces REQ-031 values.
REQ-035 Collision: key_load and rk_req in the same READY cycle -> no rk_valid; busy=1 on the next cycle.
